// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between the DataPath instruction-fetch port
//   (if_*) and its load/store port (d_*). One access is in flight at a time:
//   a winner is granted in IDLE, its fields are latched and presented on the
//   memory side (REQ), and the response is routed back to the owner (RESP).
//   A watchdog aborts an access that spends TIMEOUT_CYCLES cycles in REQ+RESP
//   and answers the owner with err=1, rdata=0.
//
// Optional feature (compile-time macro ARB_ROUND_ROBIN_EN):
//   defined   : contention is resolved by a last-owner flag (alternating).
//   undefined : fixed priority, the data port always beats the fetch port.
//
// Parameters
//   ADDR_WIDTH      address width of both requesters and the memory
//   DATA_WIDTH      data width; byte-enable width is DATA_WIDTH/8
//   TIMEOUT_CYCLES  cycles allowed in REQ+RESP before abort (>= 2)
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   if_req/if_addr           fetch request, held until if_gnt
//   if_gnt                   combinational accept pulse (IDLE only)
//   if_rvalid/if_rdata/if_err fetch response (registered pulse, data held)
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata/d_err    as the if_* outputs
//   mem_req                  registered memory request, held until mem_gnt
//   mem_we/mem_be/mem_addr/mem_wdata  latched fields of the current winner
//   mem_gnt                  memory accepted mem_req
//   mem_rvalid/mem_rdata     memory response (reads and writes)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_err,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds TIMEOUT_CYCLES-1 during the last allowed cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    owner_q, owner_d;        // 1 = load/store port owns the access
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [BE_WIDTH-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    if_rvalid_q, if_rvalid_d;
  logic                    if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic                    d_rvalid_q, d_rvalid_d;
  logic                    d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;

  logic                    sel_data_s;   // winner if a grant happens this cycle
  logic                    grant_s;
  logic                    timeout_s;
  logic                    resp_s;
  logic                    abort_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;        // 1 = data port was granted last

  // Contention goes to the requester that did not win last time.
  always_comb begin
    sel_data_s  = d_req & (~if_req | ~last_data_q);
    last_data_d = last_data_q;
    if (grant_s) begin
      last_data_d = sel_data_s;
    end else begin
      last_data_d = last_data_q;
    end
  end

  // Last-owner flag register; reset value points at fetch so data wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`else
  // Fixed priority: the data port always wins.
  assign sel_data_s = d_req;
`endif

  assign timeout_s = (cnt_q == CNT_LAST);

  // FSM next-state, watchdog and memory-request control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_req_d = mem_req_q;
    grant_s   = 1'b0;
    resp_s    = 1'b0;
    abort_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (if_req | d_req) begin
          grant_s   = 1'b1;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_REQ;
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Timeout beats a simultaneous mem_gnt; a mem_rvalid here is ignored.
        if (timeout_s) begin
          abort_s   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_RESP: begin
        cnt_d     = cnt_q + CNT_W'(1);
        mem_req_d = 1'b0;
        // A response arriving on the timeout cycle still counts as a response.
        if (mem_rvalid) begin
          resp_s  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Request latch and response routing.
  always_comb begin
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant_s) begin
      owner_d = sel_data_s;
      if (sel_data_s) begin
        mem_we_d    = d_we;
        mem_be_d    = d_be;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
      end else begin
        // Fetches are full-word reads.
        mem_we_d    = 1'b0;
        mem_be_d    = {BE_WIDTH{1'b1}};
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
      end
    end else begin
      owner_d = owner_q;
    end

    if_rvalid_d = (resp_s | abort_s) & ~owner_q;
    if_err_d    = abort_s & ~owner_q;
    d_rvalid_d  = (resp_s | abort_s) & owner_q;
    d_err_d     = abort_s & owner_q;

    if_rdata_d = if_rdata_q;
    if (if_rvalid_d) begin
      if_rdata_d = resp_s ? mem_rdata : '0;
    end else begin
      if_rdata_d = if_rdata_q;
    end

    d_rdata_d = d_rdata_q;
    if (d_rvalid_d) begin
      d_rdata_d = resp_s ? mem_rdata : '0;
    end else begin
      d_rdata_d = d_rdata_q;
    end
  end

  // State, latch and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign if_gnt    = grant_s & ~sel_data_s;
  assign d_gnt     = grant_s & sel_data_s;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES = 8).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// one further unit later, well away from the next edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid, if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    #1;
    n_tests++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'd0) begin
      n_fail++; $display("FAIL reset_mem: got %h expected 0", {mem_req, mem_we, mem_be, mem_addr, mem_wdata});
    end
    n_tests++;
    if ({if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata} !== 68'd0) begin
      n_fail++; $display("FAIL reset_resp: got %h expected 0", {if_rvalid, if_err, if_rdata, d_rvalid, d_err, d_rdata});
    end
    n_tests++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt, d_gnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    tick(); if_req = 1'b1; if_addr = 32'h40; #1;
    n_tests++;
    if ({if_gnt, d_gnt} !== 2'b10) begin n_fail++; $display("FAIL fetch_gnt: got %b expected 10", {if_gnt, d_gnt}); end
    tick(); if_req = 1'b0; mem_gnt = 1'b1; #1;
    n_tests++;
    if ({mem_req, mem_we, mem_addr, if_gnt} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
      n_fail++; $display("FAIL fetch_memreq: got req=%b we=%b addr=%h gnt=%b expected 1 0 40 0", mem_req, mem_we, mem_addr, if_gnt);
    end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093; #1;
    n_tests++;
    if ({mem_req, if_rvalid} !== 2'b00) begin n_fail++; $display("FAIL fetch_resp_wait: got %b expected 00", {mem_req, if_rvalid}); end
    tick(); mem_rvalid = 1'b0; mem_rdata = $urandom; #1;
    n_tests++;
    if ({if_rvalid, if_err, if_rdata, d_rvalid} !== {1'b1, 1'b0, 32'h00500093, 1'b0}) begin
      n_fail++; $display("FAIL fetch_rvalid: got v=%b e=%b d=%h dv=%b expected 1 0 00500093 0", if_rvalid, if_err, if_rdata, d_rvalid);
    end
    tick(); #1;
    n_tests++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h00500093}) begin
      n_fail++; $display("FAIL fetch_hold: got v=%b d=%h expected 0 00500093", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store();
    do_reset();
    tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; #1;
    n_tests++;
    if ({if_gnt, d_gnt} !== 2'b01) begin n_fail++; $display("FAIL store_gnt: got %b expected 01", {if_gnt, d_gnt}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        d_req = 1'b0; d_we = 1'b0; d_be = 4'hC; d_addr = $urandom; d_wdata = $urandom;
      end
      mem_gnt = (i == 3);
      #1;
      n_tests++;
      if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF}) begin
        n_fail++; $display("FAIL store_hold%0d: got req=%b we=%b be=%b a=%h d=%h expected 1 1 0011 100 deadbeef", i, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
      end
    end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
    n_tests++;
    if ({mem_req, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL store_release: got %b expected 00", {mem_req, d_rvalid}); end
    tick(); mem_rvalid = 1'b0; #1;
    n_tests++;
    if ({d_rvalid, d_err, d_rdata, if_rvalid} !== {1'b1, 1'b0, 32'h12345678, 1'b0}) begin
      n_fail++; $display("FAIL store_rvalid: got v=%b e=%b d=%h iv=%b expected 1 0 12345678 0", d_rvalid, d_err, d_rdata, if_rvalid);
    end
  endtask

  task automatic test_contention();
    bit got[$];
    bit gnt_prev;
    gnt_prev = 1'b0;
    do_reset();
    tick(); if_req = 1'b1; if_addr = 32'h1000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int c = 0; c < 60 && got.size() < 5; c++) begin
      if (c > 0) tick();
      mem_rvalid = gnt_prev;
      mem_rdata  = $urandom;
      mem_gnt    = mem_req;
      gnt_prev   = mem_gnt;
      #1;
      if (if_gnt || d_gnt) begin
        n_tests++;
        if ((if_gnt ^ d_gnt) !== 1'b1) begin n_fail++; $display("FAIL contention_onehot: got %b expected one grant", {if_gnt, d_gnt}); end
        got.push_back(d_gnt);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    n_tests++;
    if (got.size() < 5) begin n_fail++; $display("FAIL contention_count: got %0d grants expected 5", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      bit exp_d;
      exp_d = RR ? (i % 2 == 0) : 1'b1;
      n_tests++;
      if (got[i] !== exp_d) begin n_fail++; $display("FAIL contention_grant%0d: got d=%b expected d=%b", i, got[i], exp_d); end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    // A normal load first so the abort's zero rdata is visible.
    tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; #1;
    n_tests++;
    if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL to_pre_gnt: got %b expected 1", d_gnt); end
    tick(); d_req = 1'b0; mem_gnt = 1'b1;
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick(); mem_rvalid = 1'b0; #1;
    n_tests++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL to_pre_load: got v=%b d=%h expected 1 a5a5a5a5", d_rvalid, d_rdata); end
    tick(); d_req = 1'b1; d_addr = 32'h300; #1;
    n_tests++;
    if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL to_gnt: got %b expected 1", d_gnt); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) d_req = 1'b0;
      #1;
      n_tests++;
      if (k < 9) begin
        if ({d_rvalid, mem_req} !== 2'b01) begin n_fail++; $display("FAIL to_wait%0d: got rvalid/req=%b expected 01", k, {d_rvalid, mem_req}); end
      end else begin
        if ({d_rvalid, d_err, d_rdata, mem_req, if_rvalid} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL to_abort: got v=%b e=%b d=%h req=%b iv=%b expected 1 1 0 0 0", d_rvalid, d_err, d_rdata, mem_req, if_rvalid);
        end
      end
    end
    tick(); mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF; #1;
    n_tests++;
    if ({d_rvalid, d_err} !== 2'b00) begin n_fail++; $display("FAIL to_pulse: got %b expected 00", {d_rvalid, d_err}); end
    tick(); mem_rvalid = 1'b0; #1;
    n_tests++;
    if ({d_rvalid, if_rvalid, d_rdata, mem_req} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL to_late_drop: got dv=%b iv=%b d=%h req=%b expected 0 0 0 0", d_rvalid, if_rvalid, d_rdata, mem_req);
    end
  endtask

  task automatic test_rvalid_on_timeout();
    do_reset();
    tick(); if_req = 1'b1; if_addr = 32'h500; #1;
    n_tests++;
    if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL edge_gnt: got %b expected 1", if_gnt); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) if_req = 1'b0;
      mem_gnt    = (k == 1);
      mem_rvalid = (k == 8);
      mem_rdata  = 32'hCAFEF00D;
      #1;
      n_tests++;
      if (k < 9) begin
        if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL edge_early%0d: got %b expected 0", k, if_rvalid); end
      end else begin
        if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
          n_fail++; $display("FAIL edge_resp: got v=%b e=%b d=%h expected 1 0 cafef00d", if_rvalid, if_err, if_rdata);
        end
      end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_in_resp();
    do_reset();
    tick(); if_req = 1'b1; if_addr = 32'h80; #1;
    n_tests++;
    if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rr_gnt: got %b expected 1", if_gnt); end
    tick(); if_req = 1'b0; mem_gnt = 1'b1; #1;
    n_tests++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rr_req: got %b expected 1", mem_req); end
    tick(); mem_gnt = 1'b0; rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    tick(); rst = 1'b0; mem_rvalid = 1'b0; #1;
    n_tests++;
    if ({mem_req, if_rvalid, d_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rr_after: got %b expected 000", {mem_req, if_rvalid, d_rvalid}); end
    tick(); #1;
    n_tests++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rr_quiet: got v=%b d=%h expected 0 0", if_rvalid, if_rdata); end
    tick(); if_req = 1'b1; if_addr = 32'hC0; #1;
    n_tests++;
    if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rr_new_gnt: got %b expected 1", if_gnt); end
    tick(); if_req = 1'b0; mem_gnt = 1'b1; #1;
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 32'hC0}) begin n_fail++; $display("FAIL rr_new_req: got req=%b a=%h expected 1 c0", mem_req, mem_addr); end
    tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    tick(); mem_rvalid = 1'b0; #1;
    n_tests++;
    if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 32'h22222222}) begin
      n_fail++; $display("FAIL rr_new_resp: got v=%b e=%b d=%h expected 1 0 22222222", if_rvalid, if_err, if_rdata);
    end
  endtask

  // Random traffic against a transaction-level model: one access outstanding,
  // arbitration rule, latched fields and response routing.
  task automatic test_random();
    bit pend, pend_d, p_memg, p_we;
    logic [3:0] p_be;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, exp_data;
    bit exp_resp, exp_owner, m_acc, last_d, lower_if, lower_d, win_d;
    int gdel, rdel;
    pend = 1'b0; p_memg = 1'b0; exp_resp = 1'b0; m_acc = 1'b0;
    last_d = 1'b0; lower_if = 1'b0; lower_d = 1'b0;
    gdel = $urandom_range(0, 3); rdel = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      if (lower_if) begin if_req = 1'b0; lower_if = 1'b0; end
      else if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom; end
      if (lower_d) begin d_req = 1'b0; lower_d = 1'b0; end
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 1); d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (m_acc) begin
        if (rdel == 0) begin mem_rvalid = 1'b1; mem_rdata = $urandom; m_acc = 1'b0; end
        else rdel--;
      end else if (mem_req) begin
        if (gdel == 0) begin mem_gnt = 1'b1; m_acc = 1'b1; rdel = $urandom_range(0, 2); gdel = $urandom_range(0, 3); end
        else gdel--;
      end
      #1;
      n_tests++;
      if (mem_req !== (pend && !p_memg)) begin n_fail++; $display("FAIL rnd_memreq@%0d: got %b expected %b", cyc, mem_req, pend && !p_memg); end
      if (mem_gnt) begin
        n_tests++;
        if (pend_d) begin
          if ({mem_we, mem_be, mem_addr, mem_wdata} !== {p_we, p_be, p_addr, p_wdata}) begin
            n_fail++; $display("FAIL rnd_dfields@%0d: got %b %h %h %h expected %b %h %h %h", cyc, mem_we, mem_be, mem_addr, mem_wdata, p_we, p_be, p_addr, p_wdata);
          end
        end else begin
          if ({mem_we, mem_addr} !== {1'b0, p_addr}) begin
            n_fail++; $display("FAIL rnd_ifields@%0d: got we=%b a=%h expected 0 %h", cyc, mem_we, mem_addr, p_addr);
          end
        end
        p_memg = 1'b1;
      end
      n_tests++;
      if ({if_rvalid, if_err, d_rvalid, d_err} !== (exp_resp ? (exp_owner ? 4'b0010 : 4'b1000) : 4'b0000)) begin
        n_fail++; $display("FAIL rnd_rvalid@%0d: got %b expected resp=%b owner_d=%b", cyc, {if_rvalid, if_err, d_rvalid, d_err}, exp_resp, exp_owner);
      end
      if (exp_resp) begin
        n_tests++;
        if ((exp_owner ? d_rdata : if_rdata) !== exp_data) begin
          n_fail++; $display("FAIL rnd_rdata@%0d: got %h expected %h", cyc, exp_owner ? d_rdata : if_rdata, exp_data);
        end
        pend = 1'b0;
        exp_resp = 1'b0;
      end
      if (mem_rvalid) begin exp_resp = 1'b1; exp_owner = pend_d; exp_data = mem_rdata; end
      win_d = (if_req && d_req) ? (RR ? !last_d : 1'b1) : d_req;
      n_tests++;
      if (!pend && (if_req || d_req)) begin
        if ({if_gnt, d_gnt} !== {!win_d, win_d}) begin
          n_fail++; $display("FAIL rnd_gnt@%0d: got %b expected %b", cyc, {if_gnt, d_gnt}, {!win_d, win_d});
        end
        pend = 1'b1; pend_d = win_d; p_memg = 1'b0; last_d = win_d;
        if (win_d) begin p_we = d_we; p_be = d_be; p_addr = d_addr; p_wdata = d_wdata; lower_d = 1'b1; end
        else begin p_we = 1'b0; p_addr = if_addr; lower_if = 1'b1; end
      end else begin
        if ({if_gnt, d_gnt} !== 2'b00) begin n_fail++; $display("FAIL rnd_nogng@%0d: got %b expected 00", cyc, {if_gnt, d_gnt}); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_timeout();
    test_rvalid_on_timeout();
    test_reset_in_resp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
